seg7_capture: RTL and testbench

//  Receive side of the multiplexed 7-segment display interface. Samples an

---
 rtl/seg7_capture_pkg.sv | 27 ++
 rtl/seg7_capture_pattern_decode.sv | 35 +++
 rtl/seg7_capture.sv | 124 ++++++++++++
 tb/tb_seg7_capture.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/seg7_capture_pkg.sv
// Shared segment pattern constants (active-low g..a) and capture FSM types.
// The hex-to-segment encoder imports the same constants.
package seg7_capture_pkg;

    localparam logic [6:0] SEG7_HEX_0 = 7'h40;
    localparam logic [6:0] SEG7_HEX_1 = 7'h79;
    localparam logic [6:0] SEG7_HEX_2 = 7'h24;
    localparam logic [6:0] SEG7_HEX_3 = 7'h30;
    localparam logic [6:0] SEG7_HEX_4 = 7'h19;
    localparam logic [6:0] SEG7_HEX_5 = 7'h12;
    localparam logic [6:0] SEG7_HEX_6 = 7'h02;
    localparam logic [6:0] SEG7_HEX_7 = 7'h78;
    localparam logic [6:0] SEG7_HEX_8 = 7'h00;
    localparam logic [6:0] SEG7_HEX_9 = 7'h10;
    localparam logic [6:0] SEG7_HEX_A = 7'h08;
    localparam logic [6:0] SEG7_HEX_B = 7'h03;
    localparam logic [6:0] SEG7_HEX_C = 7'h46;
    localparam logic [6:0] SEG7_HEX_D = 7'h21;
    localparam logic [6:0] SEG7_HEX_E = 7'h06;
    localparam logic [6:0] SEG7_HEX_F = 7'h0E;

    typedef enum logic {
        SETTLE,
        HOLD
    } cap_state_t;

endpackage

// File: rtl/seg7_capture_pattern_decode.sv
// Inverse 7-segment table: active-low g..a pattern to hex value.
// Patterns outside the table are reported as illegal.
module seg7_pattern_decode
    import seg7_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b1;
        value = 4'h0;
        case (seg)
            SEG7_HEX_0: value = 4'h0;
            SEG7_HEX_1: value = 4'h1;
            SEG7_HEX_2: value = 4'h2;
            SEG7_HEX_3: value = 4'h3;
            SEG7_HEX_4: value = 4'h4;
            SEG7_HEX_5: value = 4'h5;
            SEG7_HEX_6: value = 4'h6;
            SEG7_HEX_7: value = 4'h7;
            SEG7_HEX_8: value = 4'h8;
            SEG7_HEX_9: value = 4'h9;
            SEG7_HEX_A: value = 4'hA;
            SEG7_HEX_B: value = 4'hB;
            SEG7_HEX_C: value = 4'hC;
            SEG7_HEX_D: value = 4'hD;
            SEG7_HEX_E: value = 4'hE;
            SEG7_HEX_F: value = 4'hF;
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Receive side of a scanned 7-segment bus: sync, stability filter,
// per-digit capture, frame tracking and protocol error reporting.
module seg7_capture
    import seg7_capture_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              seg_in,
    input  logic [N_DIGITS-1:0]     an_in,
    output logic [4*N_DIGITS-1:0]   digits_out,
    output logic [N_DIGITS-1:0]     points_out,
    output logic [N_DIGITS-1:0]     digit_valid,
    output logic                    frame_done,
    output logic                    err,
    output logic [1:0]              err_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [7:0]            seg_s1, seg_s2;
    logic [N_DIGITS-1:0]   an_s1, an_s2;
    logic [N_DIGITS+7:0]   s, s_prev;
    logic [CNT_W-1:0]      cnt;
    logic [N_DIGITS-1:0]   seen;
    cap_state_t            state, state_next;

    logic                  changed;
    logic                  commit;
    logic [N_DIGITS-1:0]   an_low;
    logic                  blank, single, multi;
    logic                  legal;
    logic [3:0]            value;

    assign s       = {an_s2, seg_s2};
    assign changed = (s != s_prev);
    assign an_low  = ~an_s2;
    assign blank   = (an_low == '0);
    assign single  = $onehot(an_low);
    assign multi   = !blank && !single;

    seg7_pattern_decode u_decode (
        .seg   (seg_s2[6:0]),
        .legal (legal),
        .value (value)
    );

    // Exactly one commit per stable window: the SETTLE->HOLD transition.
    always_comb begin
        state_next = state;
        commit     = 1'b0;
        if (changed) begin
            state_next = SETTLE;
        end else if (state == SETTLE && cnt == CNT_MAX) begin
            state_next = HOLD;
            commit     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_s1      <= '1;
            seg_s2      <= '1;
            an_s1       <= '1;
            an_s2       <= '1;
            s_prev      <= '1;
            cnt         <= '0;
            state       <= SETTLE;
            seen        <= '0;
            digits_out  <= '0;
            points_out  <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            err_code    <= 2'b00;
        end else begin
            seg_s1     <= seg_in;
            seg_s2     <= seg_s1;
            an_s1      <= an_in;
            an_s2      <= an_s1;
            s_prev     <= s;
            state      <= state_next;
            err        <= 1'b0;
            frame_done <= 1'b0;

            if (changed)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (commit && multi) begin
                err      <= 1'b1;
                err_code <= 2'b10;
            end

            if (commit && single) begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (an_low[i]) begin
                        if (legal) begin
                            digits_out[4*i +: 4] <= value;
                            points_out[i]        <= ~seg_s2[7];
                            digit_valid[i]       <= 1'b1;
                        end else begin
                            digit_valid[i] <= 1'b0;
                        end
                    end
                end
                if (!legal) begin
                    err      <= 1'b1;
                    err_code <= 2'b01;
                end
            end

            if (&seen)
                frame_done <= 1'b1;
            seen <= ((&seen) ? '0 : seen)
                  | ((commit && single && legal) ? an_low : '0);
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digits_out;
    logic [3:0]  points_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        err;
    logic [1:0]  err_code;

    int checks   = 0;
    int failures = 0;
    int frames   = 0;
    int errs     = 0;

    logic [3:0] an_pat  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_pat [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h19};

    seg7_capture #(
        .N_DIGITS      (4),
        .STABLE_CYCLES (8),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits_out  (digits_out),
        .points_out  (points_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .err         (err),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_done) frames++;
            if (err) errs++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst    = 1'b1;
        seg_in = 8'hFF;
        an_in  = 4'hF;
        step(3);
        rst = 1'b0;
        check("rst_digits", digits_out, 16'h0000);
        check("rst_valid", digit_valid, 4'h0);
        check("rst_points", points_out, 4'h0);
        check("rst_errcode", err_code, 2'b00);
        check("rst_frame", frame_done, 1'b0);

        frames = 0;
        errs   = 0;
        step(100);
        check("idle_errs", errs, 0);
        check("idle_frames", frames, 0);
        check("idle_valid", digit_valid, 4'h0);

        an_in  = 4'hE;
        seg_in = 8'hC0;
        step(9);
        check("d0_early_valid", digit_valid, 4'h0);
        step(3);
        check("d0_valid", digit_valid, 4'h1);
        check("d0_value", digits_out[3:0], 4'h0);
        check("d0_point", points_out, 4'h0);
        step(8);

        frames = 0;
        errs   = 0;
        for (int d = 0; d < 4; d++) begin
            an_in  = an_pat[d];
            seg_in = seg_pat[d];
            step(12);
        end
        an_in  = 4'hF;
        seg_in = 8'hFF;
        step(15);
        check("scan_digits", digits_out, 16'h4321);
        check("scan_points", points_out, 4'h8);
        check("scan_valid", digit_valid, 4'hF);
        check("scan_frames", frames, 1);
        check("scan_errs", errs, 0);

        errs   = 0;
        an_in  = 4'hE;
        seg_in = 8'hFF;
        step(15);
        check("illegal_errs", errs, 1);
        check("illegal_code", err_code, 2'b01);
        check("illegal_valid", digit_valid, 4'hE);
        check("illegal_digits", digits_out, 16'h4321);

        errs  = 0;
        an_in = 4'hC;
        step(15);
        check("multi_errs", errs, 1);
        check("multi_code", err_code, 2'b10);
        check("multi_digits", digits_out, 16'h4321);
        check("multi_valid", digit_valid, 4'hE);
        check("multi_points", points_out, 4'h8);
        check("no_extra_frame", frames, 1);

        an_in  = 4'hF;
        seg_in = 8'hFF;
        step(15);
        errs   = 0;
        an_in  = 4'hD;
        seg_in = 8'hF8;
        step(5);
        an_in  = 4'hF;
        seg_in = 8'hFF;
        step(15);
        check("glitch_digits", digits_out, 16'h4321);
        check("glitch_valid", digit_valid, 4'hE);
        check("glitch_errs", errs, 0);

        an_in  = 4'hB;
        seg_in = 8'h99;
        step(6);
        rst = 1'b1;
        step(1);
        check("mid_rst_digits", digits_out, 16'h0000);
        check("mid_rst_valid", digit_valid, 4'h0);
        check("mid_rst_points", points_out, 4'h0);
        check("mid_rst_code", err_code, 2'b00);
        check("mid_rst_err", err, 1'b0);
        rst = 1'b0;
        step(5);
        check("post_rst_partial", digit_valid, 4'h0);
        step(8);
        check("post_rst_valid", digit_valid, 4'h4);
        check("post_rst_digits", digits_out, 16'h0400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
